// File: rtl/ssr_sequencer.sv
// Shot sequencer for the single-shot readout counter block: issues clear/swap/readout/flag-clear
// pulses per shot, samples the returned flip decision and accumulates a flip count over a run.
module ssr_sequencer #(
    parameter int PULSE_LEN = 4,
    parameter int CNT_W     = 24,
    parameter int REP_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [REP_W-1:0] n_shots,
    input  logic [7:0]       n_swaps,
    input  logic [CNT_W-1:0] window_len,
    input  logic             flip_in,
    output logic             ssr_out,
    output logic             swap_out,
    output logic             readout_out,
    output logic             reset_out,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] flip_count,
    output logic             last_flip
);

    localparam int PW = $clog2(PULSE_LEN + 3) + 1;
    localparam int TW = (CNT_W > PW) ? CNT_W : PW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SWAP,
        S_WINDOW,
        S_READOUT,
        S_SETTLE,
        S_FLAGCLR,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TW-1:0]      r_tmr;
    logic [8:0]         r_swap_cnt;
    logic [REP_W:0]     r_shot_cnt;

    logic [REP_W-1:0]   r_n_shots;
    logic [7:0]         r_n_swaps;
    logic [CNT_W-1:0]   r_win_len;

    logic               r_sync1;
    logic               r_sync2;
    logic [REP_W-1:0]   r_flip_count;
    logic               r_last_flip;

    logic               r_ssr;
    logic               r_swap;
    logic               r_readout;
    logic               r_reset;
    logic               r_busy;
    logic               r_done;

    logic               w_tmr_clr;
    logic               w_load;
    logic               w_swap_inc;
    logic               w_shot_inc;
    logic               w_cap;
    logic               w_pulse_last;
    logic               w_settle_last;
    logic               w_win_last;
    logic [8:0]         w_swap_nxt;
    logic [REP_W:0]     w_shot_nxt;

    function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
        return (v == {REP_W{1'b1}}) ? v : v + REP_W'(1);
    endfunction

    assign w_pulse_last  = (r_tmr == TW'(PULSE_LEN - 1));
    assign w_settle_last = (r_tmr == TW'(2));
    assign w_win_last    = (r_tmr == (TW'(r_win_len) - TW'(1)));
    assign w_swap_nxt    = r_swap_cnt + 9'd1;
    assign w_shot_nxt    = r_shot_cnt + {{REP_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        w_load      = 1'b0;
        w_swap_inc  = 1'b0;
        w_shot_inc  = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tmr_clr = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (n_shots == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (w_pulse_last) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = (r_n_swaps != 8'd0) ? S_SWAP : S_READOUT;
                end
            end
            S_SWAP: begin
                if (w_pulse_last) begin
                    w_tmr_clr  = 1'b1;
                    w_swap_inc = 1'b1;
                    // A zero-length window is skipped entirely, so decide the next swap here.
                    if (r_win_len != '0) begin
                        w_state_nxt = S_WINDOW;
                    end else if (w_swap_nxt < {1'b0, r_n_swaps}) begin
                        w_state_nxt = S_SWAP;
                    end else begin
                        w_state_nxt = S_READOUT;
                    end
                end
            end
            S_WINDOW: begin
                if (w_win_last) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = (r_swap_cnt < {1'b0, r_n_swaps}) ? S_SWAP : S_READOUT;
                end
            end
            S_READOUT: begin
                if (w_pulse_last) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_tmr_clr   = 1'b1;
                    w_cap       = 1'b1;
                    w_state_nxt = S_FLAGCLR;
                end
            end
            S_FLAGCLR: begin
                if (w_pulse_last) begin
                    w_tmr_clr   = 1'b1;
                    w_shot_inc  = 1'b1;
                    w_state_nxt = (w_shot_nxt < {1'b0, r_n_shots}) ? S_CLEAR : S_DONE;
                end
            end
            S_DONE: begin
                w_tmr_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_tmr_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every transition and suppresses any capture or count in the same cycle.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_tmr_clr   = 1'b1;
            w_swap_inc  = 1'b0;
            w_shot_inc  = 1'b0;
            w_cap       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr      <= '0;
            r_swap_cnt <= '0;
            r_shot_cnt <= '0;
        end else begin
            r_tmr <= w_tmr_clr ? '0 : r_tmr + TW'(1);
            if (w_load || w_shot_inc) begin
                r_swap_cnt <= '0;
            end else if (w_swap_inc) begin
                r_swap_cnt <= w_swap_nxt;
            end
            if (w_load) begin
                r_shot_cnt <= '0;
            end else if (w_shot_inc) begin
                r_shot_cnt <= w_shot_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_n_shots <= n_shots;
            r_n_swaps <= n_swaps;
            r_win_len <= window_len;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_flip_count <= '0;
            r_last_flip  <= 1'b0;
        end else begin
            r_sync1 <= flip_in;
            r_sync2 <= r_sync1;
            if (w_load) begin
                r_flip_count <= '0;
            end else if (w_cap) begin
                r_last_flip <= r_sync2;
                if (r_sync2) begin
                    r_flip_count <= sat_inc(r_flip_count);
                end
            end
        end
    end

    // Outputs are registered from the next state so each pulse lines up with its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ssr     <= 1'b0;
            r_swap    <= 1'b0;
            r_readout <= 1'b0;
            r_reset   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ssr     <= (w_state_nxt == S_CLEAR);
            r_swap    <= (w_state_nxt == S_SWAP);
            r_readout <= (w_state_nxt == S_READOUT);
            r_reset   <= (w_state_nxt == S_FLAGCLR);
            r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign ssr_out     = r_ssr;
    assign swap_out    = r_swap;
    assign readout_out = r_readout;
    assign reset_out   = r_reset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign flip_count  = r_flip_count;
    assign last_flip   = r_last_flip;

endmodule

// File: doc/ssr_sequencer.md
# ssr_sequencer

Synchronous control sequencer that drives the single-shot readout counter block. For each shot it issues the clear (`ssr_out`), memory-swap (`swap_out`), compare (`readout_out`) and flag-clear (`reset_out`) pulses, then samples the returned `flip_in` decision. Over a programmed number of shots it accumulates a flip count, giving the experiment controller one start/done handshake per single-shot run.

## Interface
- `PULSE_LEN`, default 4: width in clk cycles of every output pulse; must be ≥ 1.
- `CNT_W`, default 24: width of `window_len`.
- `REP_W`, default 16: width of `n_shots` and `flip_count`.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `abort` in 1: when high in any non-IDLE state, return to IDLE.
- `n_shots` in REP_W: number of shots per run. Latched on start.
- `n_swaps` in 8: number of swap pulses per shot. Latched on start.
- `window_len` in CNT_W: idle cycles after each swap pulse (integration window). Latched on start.
- `flip_in` in 1: flip decision from the counter block. Asynchronous; passes through a 2-FF synchronizer.
- `ssr_out`, `swap_out`, `readout_out`, `reset_out` out 1: control pulses to the counter block.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle pulse at run end.
- `flip_count` out REP_W: number of shots that sampled flip = 1.
- `last_flip` out 1: flip value sampled in the most recent shot.

## Operation
- Reset values: all pulse outputs 0; `busy`, `done`, `last_flip` 0; `flip_count` 0; state IDLE; synchronizer 0.
- States: IDLE, CLEAR, SWAP, WINDOW, READOUT, SETTLE, FLAGCLR, DONE.
- IDLE, `start` = 1:
  - Latch the configuration inputs.
  - Clear `flip_count` and the shot counter.
  - Go to DONE if `n_shots` = 0; otherwise go to CLEAR.
- CLEAR: `ssr_out` = 1 for PULSE_LEN cycles. Then go to SWAP if the latched `n_swaps` > 0; otherwise go to READOUT.
- SWAP: `swap_out` = 1 for PULSE_LEN cycles, then go to WINDOW.
- WINDOW: all outputs low for `window_len` cycles.
  - If `window_len` = 0, the state lasts 0 cycles.
  - Then go to SWAP if swaps issued < `n_swaps`; otherwise go to READOUT.
- READOUT: `readout_out` = 1 for PULSE_LEN cycles.
- SETTLE: 3 low cycles. On the last cycle, capture the synchronized flip into `last_flip`. If it is 1, increment `flip_count`, saturating at 2^REP_W−1.
- FLAGCLR: `reset_out` = 1 for PULSE_LEN cycles. Then increment the shot counter, and go to CLEAR if shots done < `n_shots`; otherwise go to DONE.
- DONE: `done` = 1 for one cycle, `busy` = 0. Go to IDLE.
- Exactly one pulse output is high at any time; all outputs are registered.
- `start` while busy is ignored.
- `abort`:
  - Next cycle: IDLE, all pulse outputs 0, `busy` = 0, no `done`.
  - `flip_count` and `last_flip` keep their values.
  - `abort` takes priority over every state transition in the same cycle.
- `reset_n` low mid-run: all outputs go to their reset values immediately (asynchronously). No completion is signalled.
- Internal counters are wide enough that the maximum config values (`n_swaps` = 255, `window_len` = 2^CNT_W−1) never wrap.

## Timing
- `start` high at cycle 0 (accepted in IDLE) → `ssr_out` high cycles 1..P, where P = PULSE_LEN.
- Shot length L = P + n_swaps·(P + window_len) + P + 3 + P cycles.
- Shots are back-to-back: the next `ssr_out` rises the cycle after `reset_out` falls.
- `done` is high at cycle n_shots·L + 1. `busy` is high over cycles 1..n_shots·L.
- A `flip_in` change must be stable at least 2 cycles before the last SETTLE cycle to be captured.

## Test plan
- Reset: hold `reset_n` = 0 while toggling all inputs → all outputs 0, `flip_count` = 0.
- Single shot, P = 4, `n_shots` = 1, `n_swaps` = 2, `window_len` = 10, `flip_in` = 1 →
  - `ssr_out` high cycles 1–4; `swap_out` high 5–8 and 19–22; `readout_out` high 33–36; `reset_out` high 40–43.
  - `done` at cycle 44; `flip_count` = 1, `last_flip` = 1.
- `n_shots` = 3, `flip_in` per shot 1, 0, 1 → `flip_count` = 2, `last_flip` = 1, exactly 3 `ssr_out` pulses.
- `n_shots` = 0 → `done` at cycle 1, no pulse outputs, `flip_count` = 0. Separately: `n_swaps` = 0 → `readout_out` rises at cycle 5.
- `abort` during the first WINDOW → next cycle all pulses 0, `busy` = 0, no `done`. A `start` pulsed mid-run in a separate run is ignored and the run length is unchanged.
- `reset_n` dropped during READOUT → `readout_out` and `busy` fall without waiting for a clock edge. After release, a fresh start runs a normal sequence.
